// File: rtl/slice_writer_pkg.sv
// Shared constants and types for the state-memory slice writer.
package slice_writer_pkg;

  localparam int SLICE_W    = 25;
  localparam int NUM_SLICES = 64;
  localparam int ADDR_W     = 6;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // One-hot encoding so every status output is a single flop bit of the state.
  typedef enum logic [3:0] {
    IDLE  = 4'b0001,
    WAIT  = 4'b0010,
    WRITE = 4'b0100,
    DONE  = 4'b1000
  } state_t;

  localparam int IDLE_BIT  = 0;
  localparam int WAIT_BIT  = 1;
  localparam int WRITE_BIT = 2;
  localparam int DONE_BIT  = 3;

endpackage

// File: rtl/slice_writer_addr_counter.sv
// Loadable up/down address counter with a terminal-index flag.
module slice_addr_counter
  import slice_writer_pkg::*;
#(
  parameter int W   = ADDR_W,
  parameter int MAX = NUM_SLICES - 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  input  logic         up,
  output logic [W-1:0] cnt,
  output logic         last
);

  // Load takes priority over stepping; otherwise hold the current value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= {W{1'b0}};
    end else if (load) begin
      cnt <= load_val;
    end else if (en) begin
      cnt <= up ? (cnt + W'(1)) : (cnt - W'(1));
    end else begin
      cnt <= cnt;
    end
  end

  assign last = (cnt == W'(MAX));

endmodule

// File: rtl/slice_writer.sv
// Streams DEPTH lane slices into the state memory, ascending or descending.
module slice_writer
  import slice_writer_pkg::*;
#(
  parameter int N     = SLICE_W,
  parameter int DEPTH = NUM_SLICES,
  parameter int AW    = ADDR_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          dir,
  input  logic          in_valid,
  input  logic [N-1:0]  in_slice,
  output logic          in_ready,
  output logic          mem_wr,
  output logic [AW-1:0] mem_addr,
  output logic [N-1:0]  mem_wdata,
  input  logic          mem_stall,
  output logic          busy,
  output logic          done
);

  state_t        state;
  state_t        state_nxt;
  logic          dir_q;
  logic [AW-1:0] cnt;
  logic [N-1:0]  hold;

  logic          start_ok;
  logic          accept;
  logic          wr_done;
  logic          cnt_last;
  logic          addr_last;
  logic          addr_en;
  logic [AW-1:0] addr_init;

  assign start_ok  = state[IDLE_BIT] && start;
  assign accept    = state[WAIT_BIT] && in_valid;
  assign wr_done   = state[WRITE_BIT] && !mem_stall;
  assign cnt_last  = (cnt == AW'(DEPTH - 1));
  assign addr_init = (dir == DIR_UP) ? {AW{1'b0}} : AW'(DEPTH - 1);
  // The slice count ends the matrix; the address flag is a second guard
  // so an ascending walk can never step past the top index.
  assign addr_en   = wr_done && !cnt_last && !((dir_q == DIR_UP) && addr_last);

  slice_addr_counter #(
    .W   (AW),
    .MAX (DEPTH - 1)
  ) u_addr (
    .clk      (clk),
    .rst      (rst),
    .load     (start_ok),
    .load_val (addr_init),
    .en       (addr_en),
    .up       (dir_q == DIR_UP),
    .cnt      (mem_addr),
    .last     (addr_last)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; illegal encodings fall back to IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) state_nxt = WAIT;
        else       state_nxt = IDLE;
      end
      WAIT: begin
        if (in_valid) state_nxt = WRITE;
        else          state_nxt = WAIT;
      end
      WRITE: begin
        if (mem_stall)     state_nxt = WRITE;
        else if (cnt_last) state_nxt = DONE;
        else               state_nxt = WAIT;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Direction is captured only when a matrix write is launched.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dir_q <= DIR_DOWN;
    end else if (start_ok) begin
      dir_q <= dir;
    end else begin
      dir_q <= dir_q;
    end
  end

  // Slice counter: cleared at launch, advanced on each non-final write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= {AW{1'b0}};
    end else if (start_ok) begin
      cnt <= {AW{1'b0}};
    end else if (wr_done && !cnt_last) begin
      cnt <= cnt + AW'(1);
    end else begin
      cnt <= cnt;
    end
  end

  // Holding register captures the slice on handshake and drives write data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold <= {N{1'b0}};
    end else if (accept) begin
      hold <= in_slice;
    end else begin
      hold <= hold;
    end
  end

  assign mem_wdata = hold;
  assign in_ready  = state[WAIT_BIT];
  assign mem_wr    = state[WRITE_BIT];
  assign done      = state[DONE_BIT];
  assign busy      = !state[IDLE_BIT];

endmodule
